fifo_async_rst_n: RTL and testbench

Parameterized synchronous FIFO with valid/ready handshakes on both sides, asynchronous active-low reset and first-word-fall-through output. It sits between a producer and the enabled D flip-flop stage in our datapaths, absorbing bursts and back-pressure. The downstream register's `en` is driven from `out_valid && out_ready` and its `data` from `out_data`.

---
 rtl/fifo_async_rst_n.sv | 70 +++++++
 tb/tb_fifo_async_rst_n.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_async_rst_n.sv
// First-word-fall-through synchronous FIFO with valid/ready on both sides.
// Storage, pointers and occupancy clear asynchronously on async_rst_n low.
module fifo_async_rst_n #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             async_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a transfer happens on a rising edge where valid && ready on
  // that side; ready never depends on valid, and in_ready ignores out_ready.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_next;
  logic [PW-1:0]    rd_next;
  logic             push;
  logic             pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full && async_rst_n;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Explicit wrap so non-power-of-two depths work.
  assign wr_next = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
  assign rd_next = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_next;
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_async_rst_n.sv
// Directed bench for fifo_async_rst_n: a DEPTH=4 instance for the main
// scenarios and a DEPTH=3 instance for pointer wrap, each with a queue model.
module tb_fifo_async_rst_n;

  logic clk = 1'b0;
  logic async_rst_n = 1'b0;

  logic       a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [3:0] a_in_data = '0;
  logic       a_in_ready, a_out_valid, a_full, a_empty;
  logic [3:0] a_out_data;
  logic [2:0] a_count;

  logic       b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [3:0] b_in_data = '0;
  logic       b_in_ready, b_out_valid, b_full, b_empty;
  logic [3:0] b_out_data;
  logic [1:0] b_count;

  logic [3:0] exp_q[$];
  logic [3:0] exp_b[$];
  int total = 0;
  int bad = 0;

  fifo_async_rst_n #(.WIDTH(4), .DEPTH(4)) dut_a (
    .clk(clk), .async_rst_n(async_rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count), .full(a_full), .empty(a_empty)
  );

  fifo_async_rst_n #(.WIDTH(4), .DEPTH(3)) dut_b (
    .clk(clk), .async_rst_n(async_rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count), .full(b_full), .empty(b_empty)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle on the DEPTH=4 instance; starts and ends 1 time unit after a posedge.
  task automatic cycle_a(input logic iv, input logic [3:0] d, input logic ordy);
    logic do_push, do_pop;
    a_in_valid = iv; a_in_data = d; a_out_ready = ordy;
    #1;
    do_push = iv && (exp_q.size() < 4);
    do_pop  = ordy && (exp_q.size() > 0);
    check("a_in_ready", a_in_ready, exp_q.size() < 4);
    check("a_out_valid", a_out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) check("a_out_data", a_out_data, exp_q[0]);
    @(posedge clk); #1;
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(d);
    check("a_count", a_count, exp_q.size());
    check("a_full", a_full, exp_q.size() == 4);
    check("a_empty", a_empty, exp_q.size() == 0);
  endtask

  // Same for the DEPTH=3 instance; returns whether a push and a pop happened.
  task automatic cycle_b(input logic iv, input logic [3:0] d, input logic ordy,
                         output logic pushed, output logic popped);
    b_in_valid = iv; b_in_data = d; b_out_ready = ordy;
    #1;
    pushed = iv && (exp_b.size() < 3);
    popped = ordy && (exp_b.size() > 0);
    check("b_out_valid", b_out_valid, exp_b.size() > 0);
    if (exp_b.size() > 0) check("b_out_data", b_out_data, exp_b[0]);
    @(posedge clk); #1;
    if (popped) void'(exp_b.pop_front());
    if (pushed) exp_b.push_back(d);
    check("b_count", b_count, exp_b.size());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, a_count, 0);
    check({tag, "_empty"}, a_empty, 1);
    check({tag, "_full"}, a_full, 0);
    check({tag, "_out_valid"}, a_out_valid, 0);
    check({tag, "_in_ready"}, a_in_ready, 0);
    check({tag, "_out_data"}, a_out_data, 0);
    check({tag, "_b_count"}, b_count, 0);
  endtask

  initial begin
    logic pu, po;
    logic [3:0] held;
    logic stalled;
    int sent, got;
    logic [2:0] fill_cnt [5];
    fill_cnt[0] = 3'd1; fill_cnt[1] = 3'd2; fill_cnt[2] = 3'd3;
    fill_cnt[3] = 3'd4; fill_cnt[4] = 3'd4;

    // Power-on reset
    #2;
    check_reset_outputs("por");
    @(posedge clk); #1;
    async_rst_n = 1'b1;
    #1;
    check("por_release_in_ready", a_in_ready, 1);
    @(posedge clk); #1;

    // Fill and overflow: 0x5 must be dropped
    for (int i = 0; i < 5; i++) begin
      cycle_a(1'b1, 4'(i + 1), 1'b0);
      check("fill_count", a_count, fill_cnt[i]);
    end
    check("fill_full", a_full, 1);
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b0; a_out_ready = 1'b1;
      #1;
      check("drain_data", a_out_data, i + 1);
      cycle_a(1'b0, 4'h0, 1'b1);
    end
    check("drain_empty", a_empty, 1);

    // FWFT latency
    a_in_valid = 1'b1; a_in_data = 4'hA; a_out_ready = 1'b0;
    #1;
    check("fwft_before", a_out_valid, 0);
    cycle_a(1'b1, 4'hA, 1'b0);
    check("fwft_after_valid", a_out_valid, 1);
    check("fwft_after_data", a_out_data, 4'hA);
    cycle_a(1'b1, 4'hB, 1'b0);

    // Simultaneous push/pop at count=2
    cycle_a(1'b1, 4'hC, 1'b1);
    check("simul_mid_count", a_count, 2);
    check("simul_mid_head", a_out_data, 4'hB);
    cycle_a(1'b0, 4'h0, 1'b1);
    cycle_a(1'b0, 4'h0, 1'b1);
    check("simul_drained", a_empty, 1);

    // Simultaneous at empty: push only
    cycle_a(1'b1, 4'h7, 1'b1);
    check("simul_empty_count", a_count, 1);
    check("simul_empty_data", a_out_data, 4'h7);

    // Simultaneous at full: pop only, in_ready low during that cycle
    cycle_a(1'b1, 4'h8, 1'b0);
    cycle_a(1'b1, 4'h9, 1'b0);
    cycle_a(1'b1, 4'hD, 1'b0);
    a_in_valid = 1'b1; a_in_data = 4'hE; a_out_ready = 1'b1;
    #1;
    check("simul_full_in_ready", a_in_ready, 0);
    cycle_a(1'b1, 4'hE, 1'b1);
    check("simul_full_count", a_count, 3);
    check("simul_full_head", a_out_data, 4'h8);

    // Mid-operation reset with 3 words held
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    #3;
    async_rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    exp_q.delete();
    @(posedge clk); #1;
    async_rst_n = 1'b1;
    #1;
    check("mid_release_in_ready", a_in_ready, 1);
    @(posedge clk); #1;

    // Wrap on DEPTH=3: 10 words, out_ready toggling
    sent = 0; got = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 100 && got < 10; c++) begin
      logic ordy;
      ordy = (c % 2) == 0;
      if (stalled) begin
        #1;
        check("wrap_stable", b_out_data, held);
      end
      stalled = b_out_valid && !ordy;
      held = b_out_data;
      cycle_b(sent < 10, 4'(sent + 3), ordy, pu, po);
      if (pu) sent++;
      if (po) got++;
    end
    check("wrap_all_out", got, 10);
    check("wrap_empty", b_empty, 1);
    b_in_valid = 1'b0; b_out_ready = 1'b0;

    // Random soak
    for (int c = 0; c < 10000; c++) begin
      cycle_a(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
